scan_mux: RTL and testbench

Parametrised, registered N-channel multiplexer. It is the sequential successor to the structural 16:1 bit mux and supports two modes:
- Manual mode: external select.
- Scan mode: an internal pointer auto-steps through the enabled channels.

It sits between grouped sensor/status lanes and a single serial consumer. It tags every output word with its channel number and pulses a flag at the end of each scan round.

---
 rtl/scan_mux.sv | 121 ++++++++++++
 tb/tb_scan_mux.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/scan_mux.sv
// Registered N-channel mux: manual select or auto-scan over masked channels, 1-cycle latency.
// No backpressure; en=1 accepts a sample each cycle, en=0 holds data/channel and drops valid.
module scan_mux #(
    parameter int WIDTH = 1,
    parameter int NCH   = 16,
    parameter int SELW  = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NCH*WIDTH-1:0] in,
    input  logic                 en,
    input  logic                 mode,
    input  logic [SELW-1:0]      sel,
    input  logic [NCH-1:0]       mask,
    output logic [WIDTH-1:0]     out_data,
    output logic [SELW-1:0]      out_ch,
    output logic                 out_valid,
    output logic                 round_done
);

    logic [WIDTH-1:0] r_data;
    logic [SELW-1:0]  r_ch;
    logic [SELW-1:0]  r_ptr;
    logic             r_valid;
    logic             r_done;

    logic             w_man_hit;
    logic [WIDTH-1:0] w_man_data;
    logic             w_hi_hit;
    logic [SELW-1:0]  w_hi_idx;
    logic             w_lo_hit;
    logic [SELW-1:0]  w_lo_idx;
    logic             w_found;
    logic [SELW-1:0]  w_cur;
    logic [WIDTH-1:0] w_cur_data;
    logic             w_last;
    logic [SELW-1:0]  w_ptr_nxt;

    always_comb begin
        w_man_hit  = 1'b0;
        w_man_data = '0;
        for (int k = 0; k < NCH; k++) begin
            if (sel == SELW'(k)) begin
                w_man_hit  = 1'b1;
                w_man_data = in[k*WIDTH +: WIDTH];
            end
        end
    end

    // Descending sweep leaves the lowest set bit overall and the lowest at/above ptr;
    // the latter wins, otherwise the search wraps to the former.
    always_comb begin
        w_hi_hit = 1'b0;
        w_hi_idx = '0;
        w_lo_hit = 1'b0;
        w_lo_idx = '0;
        for (int k = NCH - 1; k >= 0; k--) begin
            if (mask[k]) begin
                w_lo_hit = 1'b1;
                w_lo_idx = SELW'(k);
                if (SELW'(k) >= r_ptr) begin
                    w_hi_hit = 1'b1;
                    w_hi_idx = SELW'(k);
                end
            end
        end
    end

    assign w_found   = w_lo_hit;
    assign w_cur     = w_hi_hit ? w_hi_idx : w_lo_idx;
    assign w_ptr_nxt = (w_cur == SELW'(NCH - 1)) ? '0 : w_cur + SELW'(1);

    always_comb begin
        w_cur_data = '0;
        w_last     = 1'b1;
        for (int k = 0; k < NCH; k++) begin
            if (w_cur == SELW'(k)) begin
                w_cur_data = in[k*WIDTH +: WIDTH];
            end
            if (mask[k] && (SELW'(k) > w_cur)) begin
                w_last = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_data  <= '0;
            r_ch    <= '0;
            r_ptr   <= '0;
            r_valid <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            r_done  <= 1'b0;
            // Pointer parks at 0 in manual mode so a later scan starts at the lowest channel.
            if (!mode) begin
                r_ptr <= '0;
            end
            if (en) begin
                if (!mode) begin
                    r_data  <= w_man_hit ? w_man_data : '0;
                    r_ch    <= sel;
                    r_valid <= w_man_hit;
                end else if (w_found) begin
                    r_data  <= w_cur_data;
                    r_ch    <= w_cur;
                    r_valid <= 1'b1;
                    r_done  <= w_last;
                    r_ptr   <= w_ptr_nxt;
                end
            end
        end
    end

    assign out_data   = r_data;
    assign out_ch     = r_ch;
    assign out_valid  = r_valid;
    assign round_done = r_done;

endmodule

// File: tb/tb_scan_mux.sv
// Scoreboarded bench for scan_mux: a 16x1 instance and a 5x8 instance driven by directed vectors.
module tb_scan_mux;

    typedef struct {
        string      name;
        logic       v;
        logic       d;
        logic [7:0] dat;
        logic [5:0] ch;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // 16-channel, 1-bit instance
    logic        a_rst = 1'b1, a_en = 1'b0, a_mode = 1'b0;
    logic [15:0] a_in = 16'h3c5d;
    logic [3:0]  a_sel = '0;
    logic [15:0] a_mask = '0;
    logic [0:0]  a_data;
    logic [3:0]  a_ch;
    logic        a_valid, a_done;

    // 5-channel, 8-bit instance
    logic        b_rst = 1'b1, b_en = 1'b0, b_mode = 1'b0;
    logic [39:0] b_in = {8'h55, 8'h44, 8'h33, 8'h22, 8'h11};
    logic [2:0]  b_sel = '0;
    logic [4:0]  b_mask = '0;
    logic [7:0]  b_data;
    logic [2:0]  b_ch;
    logic        b_valid, b_done;

    scan_mux #(.WIDTH(1), .NCH(16), .SELW(4)) u_a (
        .clk(clk), .rst(a_rst), .in(a_in), .en(a_en), .mode(a_mode), .sel(a_sel), .mask(a_mask),
        .out_data(a_data), .out_ch(a_ch), .out_valid(a_valid), .round_done(a_done)
    );

    scan_mux #(.WIDTH(8), .NCH(5), .SELW(3)) u_b (
        .clk(clk), .rst(b_rst), .in(b_in), .en(b_en), .mode(b_mode), .sel(b_sel), .mask(b_mask),
        .out_data(b_data), .out_ch(b_ch), .out_valid(b_valid), .round_done(b_done)
    );

    exp_t q_a[$];
    exp_t q_b[$];
    int   n_vec  = 0;
    int   n_fail = 0;

    task automatic vec_a(input string nm, input logic rst, en, mode, input logic [3:0] sel,
                         input logic [15:0] mask, input logic ev, ed, input logic [7:0] edat,
                         input logic [5:0] ech);
        exp_t e;
        @(negedge clk);
        a_rst = rst; a_en = en; a_mode = mode; a_sel = sel; a_mask = mask;
        @(posedge clk);
        #1;
        e.name = nm; e.v = ev; e.d = ed; e.dat = edat; e.ch = ech;
        q_a.push_back(e);
    endtask

    task automatic vec_b(input string nm, input logic rst, en, mode, input logic [2:0] sel,
                         input logic [4:0] mask, input logic ev, ed, input logic [7:0] edat,
                         input logic [5:0] ech);
        exp_t e;
        @(negedge clk);
        b_rst = rst; b_en = en; b_mode = mode; b_sel = sel; b_mask = mask;
        @(posedge clk);
        #1;
        e.name = nm; e.v = ev; e.d = ed; e.dat = edat; e.ch = ech;
        q_b.push_back(e);
    endtask

    // Monitor: outputs are registered, so sampling on the falling edge is stable.
    always @(negedge clk) begin
        exp_t e;
        if (q_a.size() > 0) begin
            e = q_a.pop_front();
            n_vec++;
            if (a_valid !== e.v || a_done !== e.d || {7'd0, a_data} !== e.dat || {2'd0, a_ch} !== e.ch) begin
                n_fail++;
                $display("FAIL a/%s: got v=%0b rd=%0b ch=%0d data=%h, want v=%0b rd=%0b ch=%0d data=%h",
                         e.name, a_valid, a_done, a_ch, a_data, e.v, e.d, e.ch, e.dat);
            end
        end
        if (q_b.size() > 0) begin
            e = q_b.pop_front();
            n_vec++;
            if (b_valid !== e.v || b_done !== e.d || b_data !== e.dat || {3'd0, b_ch} !== e.ch) begin
                n_fail++;
                $display("FAIL b/%s: got v=%0b rd=%0b ch=%0d data=%h, want v=%0b rd=%0b ch=%0d data=%h",
                         e.name, b_valid, b_done, b_ch, b_data, e.v, e.d, e.ch, e.dat);
            end
        end
    end

    initial begin
        logic [15:0] inv;
        inv = 16'h3c5d;

        // Reset held two edges while scan is requested
        vec_a("reset0", 1, 1, 1, 4'd0, 16'hffff, 0, 0, 8'h00, 6'd0);
        vec_a("reset1", 1, 1, 1, 4'd0, 16'hffff, 0, 0, 8'h00, 6'd0);

        // Full scan: two rounds starting at channel 0 right after reset
        for (int i = 0; i < 32; i++) begin
            vec_a("full_scan", 0, 1, 1, 4'd0, 16'hffff, 1, (i % 16) == 15,
                  {7'd0, inv[i % 16]}, 6'(i % 16));
        end

        // Manual sweep of even channels
        for (int s = 0; s < 16; s += 2) begin
            vec_a("manual", 0, 1, 0, 4'(s), 16'h0000, 1, 0, {7'd0, inv[s]}, 6'(s));
        end

        // Sparse mask 0,5,10,15
        for (int r = 0; r < 2; r++) begin
            vec_a("mask8421", 0, 1, 1, 4'd0, 16'h8421, 1, 0, 8'h01, 6'd0);
            vec_a("mask8421", 0, 1, 1, 4'd0, 16'h8421, 1, 0, 8'h00, 6'd5);
            vec_a("mask8421", 0, 1, 1, 4'd0, 16'h8421, 1, 0, 8'h01, 6'd10);
            vec_a("mask8421", 0, 1, 1, 4'd0, 16'h8421, 1, 1, 8'h00, 6'd15);
        end

        // Empty mask holds outputs
        for (int r = 0; r < 3; r++) begin
            vec_a("mask_empty", 0, 1, 1, 4'd0, 16'h0000, 0, 0, 8'h00, 6'd15);
        end

        // Single channel: every sample ends the round
        for (int r = 0; r < 3; r++) begin
            vec_a("mask_single", 0, 1, 1, 4'd0, 16'h0010, 1, 1, 8'h01, 6'd4);
        end

        // en gating: pointer sits at 5 and advances only on enabled cycles
        vec_a("en_on5",  0, 1, 1, 4'd0, 16'hffff, 1, 0, 8'h00, 6'd5);
        vec_a("en_off5", 0, 0, 1, 4'd0, 16'hffff, 0, 0, 8'h00, 6'd5);
        vec_a("en_on6",  0, 1, 1, 4'd0, 16'hffff, 1, 0, 8'h01, 6'd6);
        vec_a("en_off6", 0, 0, 1, 4'd0, 16'hffff, 0, 0, 8'h01, 6'd6);
        vec_a("en_on7",  0, 1, 1, 4'd0, 16'hffff, 1, 0, 8'h00, 6'd7);

        // Reset mid-scan, then restart at lowest enabled channel
        vec_a("mid_reset",   1, 1, 1, 4'd0, 16'h8420, 0, 0, 8'h00, 6'd0);
        vec_a("restart_lo",  0, 1, 1, 4'd0, 16'h8420, 1, 0, 8'h00, 6'd5);
        vec_a("restart_nxt", 0, 1, 1, 4'd0, 16'h8420, 1, 0, 8'h01, 6'd10);

        // Mode switches: scan->manual on the same edge, manual->scan from channel 0
        vec_a("to_manual", 0, 1, 0, 4'd3, 16'hffff, 1, 0, 8'h01, 6'd3);
        vec_a("to_scan",   0, 1, 1, 4'd3, 16'hffff, 1, 0, 8'h01, 6'd0);

        // 5-channel, 8-bit instance
        vec_b("b_reset",  1, 1, 0, 3'd0, 5'h1f, 0, 0, 8'h00, 6'd0);
        vec_b("b_manual", 0, 1, 0, 3'd2, 5'h1f, 1, 0, 8'h33, 6'd2);
        vec_b("b_sel5",   0, 1, 0, 3'd5, 5'h1f, 0, 0, 8'h00, 6'd5);
        vec_b("b_sel6",   0, 1, 0, 3'd6, 5'h1f, 0, 0, 8'h00, 6'd6);
        vec_b("b_sel7",   0, 1, 0, 3'd7, 5'h1f, 0, 0, 8'h00, 6'd7);
        for (int i = 0; i < 7; i++) begin
            vec_b("b_scan", 0, 1, 1, 3'd0, 5'h1f, 1, (i % 5) == 4,
                  8'(8'h11 * ((i % 5) + 1)), 6'(i % 5));
        end

        repeat (3) @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
